// File: rtl/ex_commit_ctrl_pkg.sv
// Shared definitions for the writeback commit controller.
// Holds the CP0 excodes, the default exception vector and the FSM state type.
// Optional statistics counters in ex_commit_ctrl are enabled by EX_COMMIT_STAT_EN.
package ex_commit_ctrl_pkg;

  localparam logic [4:0] EX_INT  = 5'h00;
  localparam logic [4:0] EX_ADEL = 5'h04;
  localparam logic [4:0] EX_ADES = 5'h05;
  localparam logic [4:0] EX_SYS  = 5'h08;
  localparam logic [4:0] EX_BP   = 5'h09;
  localparam logic [4:0] EX_RI   = 5'h0A;
  localparam logic [4:0] EX_OV   = 5'h0C;

  // BEV is fixed at 1, so the general exception entry is in kseg1 boot space.
  localparam logic [31:0] EX_VECTOR_DEF = 32'hBFC00380;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_REDIR = 1'b1
  } state_t;

endpackage

// File: rtl/ex_commit_prio.sv
// Combinational priority pick for the committing instruction.
// Order: interrupt, synchronous exception, ERET, TLB refetch.
// Ports:
//   has_int, ws_ex, ws_excode, ws_eret, ws_tlb_refetch : event sources
//   is_ex, is_eret, is_refetch : one-hot winning event (all 0 = normal commit)
//   excode : CP0 excode for the exception case
module ex_commit_prio
  import ex_commit_ctrl_pkg::*;
(
  input  logic       has_int,
  input  logic       ws_ex,
  input  logic [4:0] ws_excode,
  input  logic       ws_eret,
  input  logic       ws_tlb_refetch,
  output logic       is_ex,
  output logic       is_eret,
  output logic       is_refetch,
  output logic [4:0] excode
);

  assign is_ex      = has_int | ws_ex;
  assign is_eret    = ~is_ex & ws_eret;
  assign is_refetch = ~is_ex & ~ws_eret & ws_tlb_refetch;
  assign excode     = has_int ? EX_INT : ws_excode;

endmodule

// File: rtl/ex_commit_ctrl.sv
// Writeback commit controller feeding CP0 and redirecting fetch.
// Produces the CP0 strobes for the committing instruction, then holds a
// flush + redirect request towards fetch until it is accepted.
// Ports:
//   clk, reset                  : clock, async active-high reset
//   ws_*                        : committing instruction from WB
//   has_int, c0_epc             : from CP0
//   ws_allowin                  : WB may accept a new instruction
//   mtc0_we, wb_ex, wb_bd, eret_flush, wb_excode, wb_pc, wb_badvaddr : to CP0
//   flush_pipe                  : kill all younger stages
//   redir_valid/redir_pc/redir_ready : redirect handshake with fetch
//   stat_* (EX_COMMIT_STAT_EN)  : exception, interrupt and stall counters
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | accepting commits; strobes driven for the committing instr
// ST_REDIR | flushing; redirect to redir_pc offered until fetch accepts
module ex_commit_ctrl
  import ex_commit_ctrl_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] EX_VECTOR = PC_W'(EX_VECTOR_DEF)
)
(
  input  logic            clk,
  input  logic            reset,
  input  logic            ws_valid,
  input  logic [PC_W-1:0] ws_pc,
  input  logic            ws_bd,
  input  logic            ws_ex,
  input  logic [4:0]      ws_excode,
  input  logic [PC_W-1:0] ws_badvaddr,
  input  logic            ws_eret,
  input  logic            ws_mtc0,
  input  logic            ws_tlb_refetch,
  input  logic            has_int,
  input  logic [PC_W-1:0] c0_epc,
  output logic            ws_allowin,
  output logic            mtc0_we,
  output logic            wb_ex,
  output logic            wb_bd,
  output logic            eret_flush,
  output logic [4:0]      wb_excode,
  output logic [PC_W-1:0] wb_pc,
  output logic [PC_W-1:0] wb_badvaddr,
  output logic            flush_pipe,
  output logic            redir_valid,
  output logic [PC_W-1:0] redir_pc,
  input  logic            redir_ready
`ifdef EX_COMMIT_STAT_EN
  ,
  output logic [31:0]     stat_ex_cnt,
  output logic [31:0]     stat_int_cnt,
  output logic [31:0]     stat_stall_cnt
`endif
);

  state_t          state;
  logic            is_ex;
  logic            is_eret;
  logic            is_refetch;
  logic [4:0]      pick_code;
  logic            commit;
  logic            redirect;
  logic [PC_W-1:0] target;

  ex_commit_prio u_prio (
    .has_int        (has_int),
    .ws_ex          (ws_ex),
    .ws_excode      (ws_excode),
    .ws_eret        (ws_eret),
    .ws_tlb_refetch (ws_tlb_refetch),
    .is_ex          (is_ex),
    .is_eret        (is_eret),
    .is_refetch     (is_refetch),
    .excode         (pick_code)
  );

  // Reset gates the strobes so CP0 never sees a commit while the FSM is held.
  assign commit   = ws_valid & (state == ST_IDLE) & ~reset;
  assign redirect = commit & (is_ex | is_eret | is_refetch);

  assign wb_ex       = commit & is_ex;
  assign eret_flush  = commit & is_eret;
  assign mtc0_we     = commit & ws_mtc0 & ~is_ex;
  assign wb_excode   = wb_ex ? pick_code : 5'h00;
  assign wb_bd       = wb_ex & ws_bd;
  assign wb_pc       = ws_pc;
  assign wb_badvaddr = ws_badvaddr;

  always_comb begin
    target = ws_pc + PC_W'(4);
    if (is_ex)
      target = EX_VECTOR;
    else if (is_eret)
      target = c0_epc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      redir_pc    <= EX_VECTOR;
      redir_valid <= 1'b0;
      flush_pipe  <= 1'b0;
      ws_allowin  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (redirect) begin
            state       <= ST_REDIR;
            redir_pc    <= target;
            redir_valid <= 1'b1;
            flush_pipe  <= 1'b1;
            ws_allowin  <= 1'b0;
          end
        end
        ST_REDIR: begin
          if (redir_ready) begin
            state       <= ST_IDLE;
            redir_valid <= 1'b0;
            flush_pipe  <= 1'b0;
            ws_allowin  <= 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          redir_valid <= 1'b0;
          flush_pipe  <= 1'b0;
          ws_allowin  <= 1'b1;
        end
      endcase
    end
  end

`ifdef EX_COMMIT_STAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_ex_cnt    <= 32'd0;
      stat_int_cnt   <= 32'd0;
      stat_stall_cnt <= 32'd0;
    end else begin
      if (wb_ex)
        stat_ex_cnt <= stat_ex_cnt + 32'd1;
      if (commit & has_int)
        stat_int_cnt <= stat_int_cnt + 32'd1;
      if ((state == ST_REDIR) & ~redir_ready)
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_commit_ctrl.sv
// Self-checking bench for ex_commit_ctrl: directed table, hand-written
// corner sequences, then randomized traffic against a queue-based model.
module tb_ex_commit_ctrl;

  localparam logic [31:0] VEC = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        reset;
  logic        ws_valid, ws_bd, ws_ex, ws_eret, ws_mtc0, ws_tlb_refetch, has_int;
  logic [31:0] ws_pc, ws_badvaddr, c0_epc;
  logic [4:0]  ws_excode;
  logic        redir_ready;
  logic        ws_allowin, mtc0_we, wb_ex, wb_bd, eret_flush, flush_pipe, redir_valid;
  logic [4:0]  wb_excode;
  logic [31:0] wb_pc, wb_badvaddr, redir_pc;
`ifdef EX_COMMIT_STAT_EN
  logic [31:0] stat_ex_cnt, stat_int_cnt, stat_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_commit_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .ws_valid       (ws_valid),
    .ws_pc          (ws_pc),
    .ws_bd          (ws_bd),
    .ws_ex          (ws_ex),
    .ws_excode      (ws_excode),
    .ws_badvaddr    (ws_badvaddr),
    .ws_eret        (ws_eret),
    .ws_mtc0        (ws_mtc0),
    .ws_tlb_refetch (ws_tlb_refetch),
    .has_int        (has_int),
    .c0_epc         (c0_epc),
    .ws_allowin     (ws_allowin),
    .mtc0_we        (mtc0_we),
    .wb_ex          (wb_ex),
    .wb_bd          (wb_bd),
    .eret_flush     (eret_flush),
    .wb_excode      (wb_excode),
    .wb_pc          (wb_pc),
    .wb_badvaddr    (wb_badvaddr),
    .flush_pipe     (flush_pipe),
    .redir_valid    (redir_valid),
    .redir_pc       (redir_pc),
    .redir_ready    (redir_ready)
`ifdef EX_COMMIT_STAT_EN
    ,
    .stat_ex_cnt    (stat_ex_cnt),
    .stat_int_cnt   (stat_int_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  typedef struct {
    logic        valid, hint, ex;
    logic [4:0]  code;
    logic        eret, mtc0, refetch, bd;
    logic [31:0] pc, badv, epc;
    logic        e_ex;
    logic [4:0]  e_code;
    logic        e_eret, e_mtc0, e_redir;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clear_in();
    ws_valid = 1'b0; ws_bd = 1'b0; ws_ex = 1'b0; ws_eret = 1'b0; ws_mtc0 = 1'b0;
    ws_tlb_refetch = 1'b0; has_int = 1'b0; ws_excode = 5'h00;
    ws_pc = 32'h0; ws_badvaddr = 32'h0; c0_epc = 32'h0;
  endtask

  // One exception commit, held off by 'stalls' cycles of redir_ready=0.
  task automatic do_event(input logic use_int, input int stalls);
    @(negedge clk);
    clear_in();
    ws_valid = 1'b1; ws_ex = 1'b1; ws_excode = 5'h0A; has_int = use_int;
    redir_ready = 1'b0;
    @(posedge clk);
    for (int s = 0; s <= stalls; s++) begin
      @(negedge clk);
      clear_in();
      redir_ready = (s == stalls);
      @(posedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] pend[$];

  initial begin
    //              val  int  ex   code   eret mtc0 ref  bd   pc            badv          epc            e_ex code   eret mtc0 redir pc
    vecs[0] = '{1'b1,1'b0,1'b1,5'h04,1'b0,1'b0,1'b0,1'b1,32'hBFC01000,32'h00001003,32'h0,       1'b1,5'h04,1'b0,1'b0,1'b1,VEC};
    vecs[1] = '{1'b1,1'b1,1'b1,5'h0C,1'b0,1'b1,1'b0,1'b0,32'h80001234,32'h0,       32'h0,       1'b1,5'h00,1'b0,1'b0,1'b1,VEC};
    vecs[2] = '{1'b1,1'b0,1'b0,5'h00,1'b1,1'b0,1'b0,1'b0,32'h80000040,32'h0,       32'hBFC00A00,1'b0,5'h00,1'b1,1'b0,1'b1,32'hBFC00A00};
    vecs[3] = '{1'b1,1'b0,1'b0,5'h00,1'b0,1'b0,1'b1,1'b0,32'hFFFFFFFC,32'h0,       32'h0,       1'b0,5'h00,1'b0,1'b0,1'b1,32'h00000000};
    vecs[4] = '{1'b1,1'b0,1'b0,5'h00,1'b0,1'b1,1'b0,1'b0,32'h80000100,32'h0,       32'h0,       1'b0,5'h00,1'b0,1'b1,1'b0,32'h0};
    vecs[5] = '{1'b0,1'b1,1'b1,5'h08,1'b1,1'b1,1'b1,1'b0,32'h80000200,32'h0,       32'h0,       1'b0,5'h00,1'b0,1'b0,1'b0,32'h0};
    vecs[6] = '{1'b1,1'b0,1'b1,5'h08,1'b1,1'b1,1'b1,1'b1,32'h80000300,32'h00000055,32'h12345678,1'b1,5'h08,1'b0,1'b0,1'b1,VEC};
    vecs[7] = '{1'b1,1'b0,1'b0,5'h00,1'b1,1'b0,1'b1,1'b0,32'h80000400,32'h0,       32'h80000800,1'b0,5'h00,1'b1,1'b0,1'b1,32'h80000800};
    vecs[8] = '{1'b1,1'b0,1'b0,5'h00,1'b0,1'b0,1'b0,1'b0,32'h80000500,32'h0,       32'h0,       1'b0,5'h00,1'b0,1'b0,1'b0,32'h0};

    // Reset, with a would-be exception on the inputs.
    clear_in();
    reset = 1'b1; redir_ready = 1'b1;
    ws_valid = 1'b1; ws_ex = 1'b1;
    #2;
    chk("rst_wb_ex", {31'b0, wb_ex}, 32'd0);
    chk("rst_redir_valid", {31'b0, redir_valid}, 32'd0);
    chk("rst_flush", {31'b0, flush_pipe}, 32'd0);
    @(negedge clk);
    clear_in();
    reset = 1'b0;
    #1;
    chk("rst_allowin", {31'b0, ws_allowin}, 32'd1);
    chk("rst_redir_pc", redir_pc, VEC);

    // Directed table.
    foreach (vecs[i]) begin
      @(negedge clk);
      ws_valid = vecs[i].valid; has_int = vecs[i].hint; ws_ex = vecs[i].ex;
      ws_excode = vecs[i].code; ws_eret = vecs[i].eret; ws_mtc0 = vecs[i].mtc0;
      ws_tlb_refetch = vecs[i].refetch; ws_bd = vecs[i].bd; ws_pc = vecs[i].pc;
      ws_badvaddr = vecs[i].badv; c0_epc = vecs[i].epc; redir_ready = 1'b1;
      #1;
      chk($sformatf("v%0d_allowin", i), {31'b0, ws_allowin}, 32'd1);
      chk($sformatf("v%0d_wb_ex", i), {31'b0, wb_ex}, {31'b0, vecs[i].e_ex});
      chk($sformatf("v%0d_excode", i), {27'b0, wb_excode}, {27'b0, vecs[i].e_code});
      chk($sformatf("v%0d_eret_flush", i), {31'b0, eret_flush}, {31'b0, vecs[i].e_eret});
      chk($sformatf("v%0d_mtc0_we", i), {31'b0, mtc0_we}, {31'b0, vecs[i].e_mtc0});
      chk($sformatf("v%0d_wb_bd", i), {31'b0, wb_bd}, {31'b0, vecs[i].e_ex & vecs[i].bd});
      chk($sformatf("v%0d_wb_pc", i), wb_pc, vecs[i].pc);
      if (vecs[i].e_ex)
        chk($sformatf("v%0d_badvaddr", i), wb_badvaddr, vecs[i].badv);
      @(negedge clk);
      clear_in();
      #1;
      chk($sformatf("v%0d_redir_valid", i), {31'b0, redir_valid}, {31'b0, vecs[i].e_redir});
      chk($sformatf("v%0d_flush", i), {31'b0, flush_pipe}, {31'b0, vecs[i].e_redir});
      if (vecs[i].e_redir) begin
        chk($sformatf("v%0d_redir_pc", i), redir_pc, vecs[i].e_pc);
        @(negedge clk);
        #1;
        chk($sformatf("v%0d_back_idle", i), {30'b0, redir_valid, ws_allowin}, 32'd1);
      end
    end

    // ERET with three stall cycles; commits offered during REDIR are ignored.
    begin
      int eret_pulses;
      eret_pulses = 0;
      @(negedge clk);
      clear_in();
      ws_valid = 1'b1; ws_eret = 1'b1; c0_epc = 32'hBFC00A00; redir_ready = 1'b0;
      #1;
      eret_pulses += int'(eret_flush);
      for (int s = 0; s < 4; s++) begin
        @(negedge clk);
        clear_in();
        ws_valid = 1'b1; ws_ex = 1'b1; ws_eret = 1'b1; ws_mtc0 = 1'b1; has_int = 1'b1;
        c0_epc = 32'h11111110;
        redir_ready = (s == 3);
        #1;
        eret_pulses += int'(eret_flush);
        chk($sformatf("stall%0d_redir_valid", s), {31'b0, redir_valid}, 32'd1);
        chk($sformatf("stall%0d_redir_pc", s), redir_pc, 32'hBFC00A00);
        chk($sformatf("stall%0d_allowin", s), {31'b0, ws_allowin}, 32'd0);
        chk($sformatf("stall%0d_ignored", s), {30'b0, wb_ex, mtc0_we}, 32'd0);
      end
      @(negedge clk);
      clear_in();
      redir_ready = 1'b1;
      #1;
      chk("stall_eret_pulses", eret_pulses, 32'd1);
      chk("stall_back_idle", {30'b0, redir_valid, ws_allowin}, 32'd1);
    end

    // Asynchronous reset in the middle of a redirect.
    @(negedge clk);
    clear_in();
    ws_valid = 1'b1; ws_tlb_refetch = 1'b1; ws_pc = 32'h00000100; redir_ready = 1'b0;
    @(negedge clk);
    clear_in();
    #1;
    chk("midrst_pre_valid", {31'b0, redir_valid}, 32'd1);
    chk("midrst_pre_pc", redir_pc, 32'h00000104);
    #1 reset = 1'b1;
    #1;
    chk("midrst_redir_valid", {31'b0, redir_valid}, 32'd0);
    chk("midrst_flush", {31'b0, flush_pipe}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    redir_ready = 1'b1;
    #1;
    chk("midrst_allowin", {31'b0, ws_allowin}, 32'd1);
    chk("midrst_redir_pc", redir_pc, VEC);

`ifdef EX_COMMIT_STAT_EN
    do_event(1'b0, 2);
    do_event(1'b1, 0);
    do_event(1'b0, 0);
    @(negedge clk);
    #1;
    chk("stat_ex_cnt", stat_ex_cnt, 32'd3);
    chk("stat_int_cnt", stat_int_cnt, 32'd1);
    chk("stat_stall_cnt", stat_stall_cnt, 32'd2);
`else
    do_event(1'b0, 2);
    @(negedge clk);
    #1;
    chk("event_back_idle", {30'b0, redir_valid, ws_allowin}, 32'd1);
`endif

    // Randomized traffic against a pending-redirect queue model.
    pend.delete();
    for (int c = 0; c < 500; c++) begin
      logic busy, take, exc;
      logic [4:0] ecode;
      @(negedge clk);
      ws_valid = ($urandom_range(0, 9) < 7);
      has_int = ($urandom_range(0, 9) == 0);
      ws_ex = ($urandom_range(0, 4) == 0);
      ws_excode = 5'($urandom_range(0, 31));
      ws_eret = ($urandom_range(0, 6) == 0);
      ws_tlb_refetch = ($urandom_range(0, 6) == 0);
      ws_mtc0 = ($urandom_range(0, 2) == 0);
      ws_bd = 1'($urandom_range(0, 1));
      ws_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
      ws_badvaddr = $urandom;
      c0_epc = $urandom;
      redir_ready = ($urandom_range(0, 9) < 6);
      #1;
      busy = (pend.size() != 0);
      take = ws_valid && !busy;
      exc = has_int || ws_ex;
      ecode = has_int ? 5'h00 : ws_excode;
      chk("rnd_allowin", {31'b0, ws_allowin}, {31'b0, !busy});
      chk("rnd_redir_valid", {31'b0, redir_valid}, {31'b0, busy});
      chk("rnd_flush", {31'b0, flush_pipe}, {31'b0, busy});
      if (busy)
        chk("rnd_redir_pc", redir_pc, pend[0]);
      chk("rnd_wb_ex", {31'b0, wb_ex}, {31'b0, take && exc});
      if (take && exc) begin
        chk("rnd_excode", {27'b0, wb_excode}, {27'b0, ecode});
        chk("rnd_wb_bd", {31'b0, wb_bd}, {31'b0, ws_bd});
      end
      chk("rnd_eret_flush", {31'b0, eret_flush}, {31'b0, take && !exc && ws_eret});
      chk("rnd_mtc0_we", {31'b0, mtc0_we}, {31'b0, take && !exc && ws_mtc0});
      if (busy && redir_ready)
        void'(pend.pop_front());
      if (take) begin
        if (exc)
          pend.push_back(VEC);
        else if (ws_eret)
          pend.push_back(c0_epc);
        else if (ws_tlb_refetch)
          pend.push_back(ws_pc + 32'd4);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_commit_ctrl.md
Name: ex_commit_ctrl

Overview:
- Writeback-stage commit controller that sits directly upstream of the CP0 register file.
- Turns the instruction committing in WB into the CP0 control strobes: wb_ex, wb_excode, wb_bd, wb_pc, wb_badvaddr, eret_flush and mtc0_we. Interrupts sampled from CP0 are merged in at this point.
- Sequences the pipeline flush and the fetch redirect (exception vector, EPC, or TLB-op refetch) with a valid/ready handshake to the fetch stage.

Parameters:
- EX_VECTOR, 32'hBFC00380, exception entry PC (BEV fixed at 1).
- PC_W, 32, PC and address width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ws_valid  in  1  WB stage holds a committing instruction
- ws_pc  in  PC_W  PC of the committing instruction
- ws_bd  in  1  instruction is in a branch delay slot
- ws_ex  in  1  synchronous exception detected upstream
- ws_excode  in  5  excode of ws_ex
- ws_badvaddr  in  PC_W  faulting address
- ws_eret  in  1  instruction is ERET
- ws_mtc0  in  1  instruction is MTC0
- ws_tlb_refetch  in  1  TLBWI/TLBR; mapping changed, refetch next PC
- has_int  in  1  pending enabled interrupt from CP0
- c0_epc  in  PC_W  EPC from CP0
- ws_allowin  out  1  WB may accept a new instruction
- mtc0_we  out  1  CP0 write enable
- wb_ex, wb_bd, eret_flush  out  1  CP0 strobes
- wb_excode  out  5  CP0 excode
- wb_pc, wb_badvaddr  out  PC_W  CP0 PC and bad address
- flush_pipe  out  1  kill all younger stages
- redir_valid  out  1  redirect request to fetch
- redir_pc  out  PC_W  redirect target
- redir_ready  in  1  fetch accepts the redirect

Behaviour:
- Commit event: a cycle with ws_valid=1 while the FSM is in IDLE.
- Priority, highest first:
  - INT: has_int → excode 5'h00. Overrides ws_ex and ws_eret.
  - ws_ex → ws_excode.
  - ws_eret.
  - ws_tlb_refetch.
  - none → normal commit.
- Exception (INT or ws_ex), combinational in the commit cycle:
  - wb_ex=1; wb_excode per priority.
  - wb_bd=ws_bd; wb_pc=ws_pc; wb_badvaddr=ws_badvaddr.
  - mtc0_we=0.
  - Latch redir_pc=EX_VECTOR.
- ERET (no exception): eret_flush=1 for one cycle; latch redir_pc=c0_epc as sampled in that same cycle.
- Refetch (none of the above): latch redir_pc=ws_pc+4, wrapping modulo 2^PC_W.
- mtc0_we = ws_valid & ws_mtc0 & ~exception & state==IDLE.
- wb_ex and eret_flush are single-cycle pulses in the commit cycle only; never asserted outside IDLE.
- FSM states:
  - IDLE: ws_allowin=1, redir_valid=0, flush_pipe=0. Moves to REDIR on an exception, ERET or refetch commit.
  - REDIR: redir_valid=1, flush_pipe=1, ws_allowin=0, redir_pc held stable. Returns to IDLE in the cycle after redir_valid&redir_ready.
- Latency: redir_valid rises exactly 1 cycle after the commit pulse. A fetch stage with redir_ready tied high completes the handshake in that cycle, so each event costs 2 cycles minimum.
- ws_valid inputs seen in REDIR are ignored (treated as flushed): no strobes, no state change.
- has_int is ignored while ws_valid=0; an interrupt is taken only on a valid committing instruction.
- Reset (asynchronous, any state including mid-REDIR):
  - state=IDLE; redir_pc=EX_VECTOR.
  - All strobes 0; redir_valid=0; flush_pipe=0; ws_allowin=1 after reset deasserts.
- Widths: wb_excode is always 5 bits; no truncation anywhere else.

Optional Feature:
- Macro EX_COMMIT_STAT_EN.
- Defined: adds outputs stat_ex_cnt[31:0], stat_int_cnt[31:0] and stat_stall_cnt[31:0].
  - stat_ex_cnt increments on every wb_ex pulse.
  - stat_int_cnt increments on INT commits.
  - stat_stall_cnt increments each REDIR cycle with redir_ready=0.
  - All wrap at 2^32 and clear on reset.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package/header:
  - EX_INT=5'h00, EX_ADEL=5'h04, EX_ADES=5'h05, EX_SYS=5'h08, EX_BP=5'h09, EX_RI=5'h0A, EX_OV=5'h0C.
  - EX_VECTOR default.
  - FSM state encoding (IDLE=1'b0, REDIR=1'b1).
- One sub-module, ex_commit_prio: purely combinational priority pick producing {is_ex, is_eret, is_refetch, excode}. The FSM and the redirect register stay in ex_commit_ctrl.

Test Plan:
- ws_valid=1, ws_ex=1, ws_excode=5'h04, ws_pc=0xBFC01000, ws_bd=1, ws_badvaddr=0x1003, redir_ready=1:
  - Same cycle: wb_ex=1, wb_excode=0x04, wb_bd=1, wb_pc=0xBFC01000, wb_badvaddr=0x1003.
  - Next cycle: redir_valid=1, redir_pc=0xBFC00380.
  - Cycle after: IDLE.
- ws_eret=1, c0_epc=0xBFC00A00, redir_ready=0 for 3 cycles then 1:
  - eret_flush pulses once.
  - redir_valid held 4 cycles with redir_pc=0xBFC00A00, ws_allowin=0 throughout, then IDLE.
- has_int=1, ws_mtc0=1, ws_ex=1 (excode 0x0C), all in one commit:
  - wb_excode=0x00, mtc0_we=0, redir_pc=0xBFC00380.
- ws_tlb_refetch=1, ws_pc=0xFFFFFFFC → redir_pc=0x00000000 (wrap), wb_ex=0.
- Reset asserted mid-REDIR (asynchronous) → redir_valid and flush_pipe drop immediately; ws_allowin=1 after reset deasserts.
- EX_COMMIT_STAT_EN: 3 exceptions, 1 of them INT, with 2 stall cycles → stat_ex_cnt=3, stat_int_cnt=1, stat_stall_cnt=2.
